// File: rtl/neopix_pkg.sv
// Shared state type, default WS2812 timing and GRB field layout for the
// frame-buffer-to-strip transmitter.
package neopix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH
    } state_t;

    localparam int unsigned DEF_BIT_CYCLES   = 63;
    localparam int unsigned DEF_T0H_CYCLES   = 20;
    localparam int unsigned DEF_T1H_CYCLES   = 40;
    localparam int unsigned DEF_LATCH_CYCLES = 3000;

    // Frame-buffer read port: registered address plus registered data.
    localparam int unsigned RD_LATENCY = 2;

    localparam int unsigned PIX_BITS = 24;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned G_LSB    = 16;
    localparam int unsigned R_LSB    = 8;
    localparam int unsigned B_LSB    = 0;

    // Wire order on the strip is G, R, B with each field MSB first.
    function automatic logic [PIX_BITS-1:0] grb_word(input logic [PIX_BITS-1:0] word);
        return {word[G_LSB +: FIELD_W], word[R_LSB +: FIELD_W], word[B_LSB +: FIELD_W]};
    endfunction

endpackage

// File: rtl/neopix_bit_cell.sv
// One WS2812 bit cell: BIT_CYCLES long, high for T1H or T0H cycles from the
// load edge, low for the remainder; cell_end flags the last cycle.
module neopix_bit_cell
    import neopix_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int unsigned T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES = DEF_T1H_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic bit_val,
    output logic level,
    output logic cell_end
);
    localparam int unsigned CNT_W = $clog2(BIT_CYCLES);

    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0_LAST   = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1_LAST   = CNT_W'(T1H_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_last;
    logic             active;

    assign cell_end = active && (cnt == CELL_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            high_last <= '0;
            active    <= 1'b0;
            level     <= 1'b0;
        end else if (load) begin
            // A load on the cell_end cycle chains cells with no gap.
            cnt       <= '0;
            high_last <= bit_val ? T1_LAST : T0_LAST;
            active    <= 1'b1;
            level     <= 1'b1;
        end else if (active) begin
            if (cnt == CELL_LAST) begin
                active <= 1'b0;
                level  <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == high_last) begin
                    level <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/neopix_frame_tx.sv
// Reads pixels from the frame buffer (2-cycle read latency) and serializes
// one frame as a WS2812 waveform, followed by the latch gap.
module neopix_frame_tx
    import neopix_pkg::*;
#(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_pixels,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [31:0]       q,
    output logic              dout
);
    localparam int unsigned PIX_W = ADDR_W + 1;
    localparam int unsigned LAT_W = $clog2(LATCH_CYCLES);
    localparam int unsigned RL_W  = $clog2(RD_LATENCY + 1);
    localparam int unsigned IDX_W = $clog2(PIX_BITS);

    localparam logic [PIX_W-1:0] MAX_PIX  = PIX_W'(1) << ADDR_W;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [RL_W-1:0]  RL_LAST  = RL_W'(RD_LATENCY);
    localparam logic [IDX_W-1:0] TOP_BIT  = IDX_W'(PIX_BITS - 1);

    state_t              state;
    logic [PIX_W-1:0]    count;
    logic [PIX_W-1:0]    pix_idx;
    logic [PIX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    bit_idx;
    logic [PIX_BITS-1:0] shreg;
    logic [PIX_BITS-1:0] next_pix;
    logic [PIX_BITS-1:0] q_pix;
    logic [RL_W-1:0]     fetch_cnt;
    logic [RL_W-1:0]     pf_cnt;
    logic                pf_busy;
    logic [LAT_W-1:0]    latch_cnt;

    logic cell_end;
    logic cell_load;
    logic cell_bit;
    logic fetch_hit;
    logic shift_next;
    logic pixel_next;
    logic pf_issue;
    logic unused_q_hi;

    assign q_pix       = grb_word(q[PIX_BITS-1:0]);
    assign unused_q_hi = &q[31:PIX_BITS];

    always_comb begin
        fetch_hit  = (state == FETCH) && (fetch_cnt == RL_LAST);
        shift_next = (state == SHIFT) && cell_end && (bit_idx != '0);
        pixel_next = (state == SHIFT) && cell_end && (bit_idx == '0)
                     && ((pix_idx + PIX_W'(1)) != count);
        next_idx   = fetch_hit ? '0 : pix_idx + PIX_W'(1);
        // Prefetch the following pixel as soon as a pixel's first cell starts.
        pf_issue   = (fetch_hit || pixel_next) && ((next_idx + PIX_W'(1)) < count);
        cell_load  = fetch_hit || shift_next || pixel_next;
        if (fetch_hit) begin
            cell_bit = q_pix[PIX_BITS-1];
        end else if (shift_next) begin
            cell_bit = shreg[PIX_BITS-2];
        end else begin
            cell_bit = next_pix[PIX_BITS-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            pix_idx   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            next_pix  <= '0;
            fetch_cnt <= '0;
            pf_cnt    <= '0;
            pf_busy   <= 1'b0;
            latch_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdaddress <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (num_pixels != '0)) begin
                        count     <= (num_pixels > MAX_PIX) ? MAX_PIX : num_pixels;
                        pix_idx   <= '0;
                        fetch_cnt <= '0;
                        rdaddress <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_hit) begin
                        shreg   <= q_pix;
                        bit_idx <= TOP_BIT;
                        state   <= SHIFT;
                    end else begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_next) begin
                        shreg   <= shreg << 1;
                        bit_idx <= bit_idx - 1'b1;
                    end else if (pixel_next) begin
                        shreg   <= next_pix;
                        bit_idx <= TOP_BIT;
                        pix_idx <= pix_idx + PIX_W'(1);
                    end else if (cell_end) begin
                        latch_cnt <= '0;
                        state     <= LATCH;
                    end
                end
                LATCH: begin
                    if (latch_cnt == LAT_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pf_issue) begin
                rdaddress <= ADDR_W'(next_idx + PIX_W'(1));
                pf_cnt    <= '0;
                pf_busy   <= 1'b1;
            end else if (pf_busy) begin
                if (pf_cnt == RL_LAST) begin
                    next_pix <= q_pix;
                    pf_busy  <= 1'b0;
                end else begin
                    pf_cnt <= pf_cnt + 1'b1;
                end
            end
        end
    end

    neopix_bit_cell #(
        .BIT_CYCLES(BIT_CYCLES),
        .T0H_CYCLES(T0H_CYCLES),
        .T1H_CYCLES(T1H_CYCLES)
    ) u_cell (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cell_load),
        .bit_val (cell_bit),
        .level   (dout),
        .cell_end(cell_end)
    );

endmodule

// File: tb/tb_neopix_frame_tx.sv
// Scoreboard bench for neopix_frame_tx: stimulus queues expected bits,
// addresses and frame lengths; a monitor decodes dout and compares.
module tb_neopix_frame_tx;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NPIX   = 1 << ADDR_W;
    localparam int          BITC   = 63;
    localparam int          T0H    = 20;
    localparam int          T1H    = 40;
    localparam int          LATCH  = 3000;

    logic              clock      = 1'b0;
    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic [ADDR_W:0]   num_pixels = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rdaddress;
    logic [31:0]       q;
    logic              dout;

    logic [31:0]       mem [NPIX];
    logic [ADDR_W-1:0] addr_q;

    int errors = 0;
    int checks = 0;

    bit exp_bits[$];
    int exp_addr[$];
    int exp_busy[$];

    neopix_frame_tx #(
        .ADDR_W(ADDR_W),
        .BIT_CYCLES(BITC),
        .T0H_CYCLES(T0H),
        .T1H_CYCLES(T1H),
        .LATCH_CYCLES(LATCH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .num_pixels(num_pixels),
        .busy      (busy),
        .done      (done),
        .rdaddress (rdaddress),
        .q         (q),
        .dout      (dout)
    );

    always #10 clock = ~clock;

    // Frame-buffer read port model: registered address, registered data.
    always @(posedge clock) begin
        addr_q <= rdaddress;
        q      <= mem[addr_q];
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pop_addr(input string name);
        check({name, "_expected"}, int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) check(name, int'(rdaddress), exp_addr.pop_front());
    endtask

    // ---------------- monitor ----------------
    bit   in_cell, prev_d, prev_busy, prev_done;
    int   pos, hi, gap, frame_cells, busy_cnt;
    logic [ADDR_W-1:0] prev_addr;

    always @(negedge clock) begin
        if (!reset_n) begin
            in_cell = 0; prev_d = 0; prev_busy = 0; prev_done = 0;
            pos = 0; hi = 0; gap = 0; frame_cells = 0; busy_cnt = 0;
            prev_addr = '0;
        end else begin
            if (busy && !prev_busy) begin
                busy_cnt = 0; frame_cells = 0; gap = 0;
                pop_addr("rdaddr_first");
            end else if (busy && rdaddress != prev_addr) begin
                pop_addr("rdaddr_next");
            end
            prev_addr = rdaddress;
            if (busy) busy_cnt++;

            if (dout && !prev_d) begin
                if (in_cell) check("cell_len", pos, BITC);
                else if (frame_cells == 0) check("first_rise_delay", busy_cnt - 1, 3);
                else check("seam_gap", gap, 0);
                in_cell = 1; pos = 1; hi = 1; gap = 0;
            end else if (in_cell) begin
                pos++;
                if (dout) hi++;
            end else if (frame_cells > 0 && busy) begin
                gap++;
            end

            if (in_cell && pos == BITC) begin
                in_cell = 0;
                frame_cells++;
                check("bit_expected", int'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) check("high_width", hi, exp_bits.pop_front() ? T1H : T0H);
            end

            if (!busy && prev_busy) check("busy_fall_with_done", int'(done), 1);

            if (done) begin
                check("done_expected", int'(exp_busy.size() > 0), 1);
                if (exp_busy.size() > 0) begin
                    check("busy_len", busy_cnt, exp_busy.pop_front());
                    check("busy_at_done", int'(busy), 0);
                    check("latch_gap", gap, LATCH);
                    check("bits_left", exp_bits.size(), 0);
                    check("addrs_left", exp_addr.size(), 0);
                end
                check("done_width", int'(prev_done), 0);
            end

            prev_d = dout; prev_busy = busy; prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic issue(input int n, input int count);
        for (int p = 0; p < count; p++) begin
            exp_addr.push_back(p);
            for (int b = 23; b >= 0; b--) exp_bits.push_back(mem[p][b]);
        end
        if (count > 0) exp_busy.push_back(3 + count * 24 * BITC + LATCH);
        start      = 1'b1;
        num_pixels = (ADDR_W + 1)'(n);
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock); #1;
            if (done) seen = 1;
        end
        check("done_within_budget", int'(seen), 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rdaddress", int'(rdaddress), 0);
        #1 reset_n = 1'b1;
        @(negedge clock); #1;

        // Single pixel: G=A5, R=00, B=FF.
        mem[0] = 32'h00A5_00FF;
        issue(1, 1);
        wait_done(6000);

        // Three-pixel seam, with a start pulse during busy that must be ignored.
        mem[0] = 32'h00FF_FFFF;
        mem[1] = 32'h0000_0000;
        mem[2] = 32'h0080_0001;
        issue(3, 3);
        repeat (200) @(negedge clock);
        #1 start = 1'b1; num_pixels = 5;
        @(negedge clock); #1 start = 1'b0;
        wait_done(10000);

        // Full buffer, then an over-range count, back to back after done.
        for (int i = 0; i < NPIX; i++)
            mem[i] = {8'hC3, 8'(i * 33), ~8'(i), 8'((i << 5) | i)};
        issue(NPIX, NPIX);
        wait_done(20000);
        issue(NPIX + 4, NPIX);
        wait_done(20000);

        // Zero-pixel start is ignored.
        issue(0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            check("zero_busy", int'(busy), 0);
        end

        // Reset during pixel 1, bit 10, while dout is high.
        mem[0] = 32'h0012_3456;
        mem[1] = 32'h00FF_FFFF;
        mem[2] = 32'h0055_AA55;
        issue(3, 3);
        repeat (2338) @(negedge clock);
        check("pre_reset_dout", int'(dout), 1);
        check("pre_reset_rdaddress", int'(rdaddress), 2);
        #3 reset_n = 1'b0;
        exp_bits.delete();
        exp_addr.delete();
        exp_busy.delete();
        #1;
        check("abort_dout", int'(dout), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_rdaddress", int'(rdaddress), 0);
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock); #1;

        // Upper byte ignored: 24 zero cells.
        mem[0] = 32'hFF00_0000;
        issue(1, 1);
        wait_done(6000);

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
